// File: rtl/dp_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dp_pkg
// Desc     : Shared types and encodings for the data-processing controller.
// Revision : 1.0 - initial release
// ============================================================================
package dp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    // Shift operation: {type, 1'b0} shifts by immediate, {type, 1'b1} by Rs[7:0]
    localparam logic [2:0] c_sh_lsl_imm = 3'b000;
    localparam logic [2:0] c_sh_lsl_reg = 3'b001;
    localparam logic [2:0] c_sh_lsr_imm = 3'b010;
    localparam logic [2:0] c_sh_lsr_reg = 3'b011;
    localparam logic [2:0] c_sh_asr_imm = 3'b100;
    localparam logic [2:0] c_sh_asr_reg = 3'b101;
    localparam logic [2:0] c_sh_ror_imm = 3'b110;
    localparam logic [2:0] c_sh_ror_reg = 3'b111;

    localparam logic [3:0] c_op_and = 4'b0000;
    localparam logic [3:0] c_op_eor = 4'b0001;
    localparam logic [3:0] c_op_sub = 4'b0010;
    localparam logic [3:0] c_op_rsb = 4'b0011;
    localparam logic [3:0] c_op_add = 4'b0100;
    localparam logic [3:0] c_op_adc = 4'b0101;
    localparam logic [3:0] c_op_sbc = 4'b0110;
    localparam logic [3:0] c_op_rsc = 4'b0111;
    localparam logic [3:0] c_op_tst = 4'b1000;
    localparam logic [3:0] c_op_teq = 4'b1001;
    localparam logic [3:0] c_op_cmp = 4'b1010;
    localparam logic [3:0] c_op_cmn = 4'b1011;
    localparam logic [3:0] c_op_orr = 4'b1100;
    localparam logic [3:0] c_op_mov = 4'b1101;
    localparam logic [3:0] c_op_bic = 4'b1110;
    localparam logic [3:0] c_op_mvn = 4'b1111;

    localparam logic [3:0] c_cond_eq = 4'b0000;
    localparam logic [3:0] c_cond_ne = 4'b0001;
    localparam logic [3:0] c_cond_cs = 4'b0010;
    localparam logic [3:0] c_cond_cc = 4'b0011;
    localparam logic [3:0] c_cond_mi = 4'b0100;
    localparam logic [3:0] c_cond_pl = 4'b0101;
    localparam logic [3:0] c_cond_vs = 4'b0110;
    localparam logic [3:0] c_cond_vc = 4'b0111;
    localparam logic [3:0] c_cond_hi = 4'b1000;
    localparam logic [3:0] c_cond_ls = 4'b1001;
    localparam logic [3:0] c_cond_ge = 4'b1010;
    localparam logic [3:0] c_cond_lt = 4'b1011;
    localparam logic [3:0] c_cond_gt = 4'b1100;
    localparam logic [3:0] c_cond_le = 4'b1101;
    localparam logic [3:0] c_cond_al = 4'b1110;
    localparam logic [3:0] c_cond_nv = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// ============================================================================
// Module   : cond_check
// Desc     : Evaluates an ARM condition field against the {N,Z,C,V} flags.
// Revision : 1.0 - initial release
// ============================================================================
module cond_check
    import dp_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] NZCV,
    output logic       pass
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = NZCV[3];
    assign w_z = NZCV[2];
    assign w_c = NZCV[1];
    assign w_v = NZCV[0];

    always_comb begin
        pass = 1'b0;
        case (cond)
            c_cond_eq: pass = w_z;
            c_cond_ne: pass = !w_z;
            c_cond_cs: pass = w_c;
            c_cond_cc: pass = !w_c;
            c_cond_mi: pass = w_n;
            c_cond_pl: pass = !w_n;
            c_cond_vs: pass = w_v;
            c_cond_vc: pass = !w_v;
            c_cond_hi: pass = w_c && !w_z;
            c_cond_ls: pass = !w_c || w_z;
            c_cond_ge: pass = (w_n == w_v);
            c_cond_lt: pass = (w_n != w_v);
            c_cond_gt: pass = !w_z && (w_n == w_v);
            c_cond_le: pass = w_z || (w_n != w_v);
            c_cond_al: pass = 1'b1;
            default:   pass = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dp_controller.sv
`default_nettype none
// ============================================================================
// Module   : dp_controller
// Desc     : Four-state decode/execute sequencer for ARM data-processing ops.
// Revision : 1.0 - initial release
// ============================================================================
module dp_controller
    import dp_pkg::*;
(
    input  logic        clk,
    input  logic        Rst,
    input  logic        Inst_Valid,
    input  logic [31:0] Inst,
    output logic        Inst_Ready,
    input  logic [3:0]  NZCV,
    output logic [3:0]  Rn_Addr,
    output logic [3:0]  Rm_Addr,
    output logic [3:0]  Rs_Addr,
    output logic [3:0]  Rd_Addr,
    output logic [3:0]  ALU_OP,
    output logic [2:0]  SHIFT_OP,
    output logic [7:0]  Shift_Imm,
    output logic        Shift_Num_Sel,
    output logic        Imm_Sel,
    output logic [31:0] Imm_Out,
    output logic        LF,
    output logic        S,
    output logic        Write_Reg,
    output logic        Done,
    output logic        Skipped,
    output logic        Illegal
);

    state_t      r_state;
    logic [31:0] r_ir;
    logic        w_pass;
    logic        w_illegal;
    logic        w_is_test;

    cond_check u_cond_check (
        .cond (r_ir[31:28]),
        .NZCV (NZCV),
        .pass (w_pass)
    );

    // Compare/test class (10xx) writes nothing back and is meaningless without S
    assign w_is_test = (r_ir[24:23] == 2'b10);
    assign w_illegal = (r_ir[27:26] != 2'b00)
                     || (!r_ir[25] && r_ir[4] && r_ir[7])
                     || (w_is_test && !r_ir[20]);

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_state <= IDLE;
            r_ir    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Inst_Valid) begin
                        r_ir    <= Inst;
                        r_state <= DECODE;
                    end
                end
                DECODE:  r_state <= (w_illegal || !w_pass) ? IDLE : EXEC;
                EXEC:    r_state <= WB;
                WB:      r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Strobes are pure functions of the registered state, so none can overlap Inst_Ready
    assign Inst_Ready = (r_state == IDLE);
    assign Illegal    = (r_state == DECODE) && w_illegal;
    assign Skipped    = (r_state == DECODE) && !w_illegal && !w_pass;
    assign LF         = (r_state == EXEC);
    assign S          = (r_state == EXEC) && r_ir[20];
    assign Write_Reg  = (r_state == WB) && !w_is_test;
    assign Done       = Illegal || Skipped || (r_state == WB);

    always_comb begin
        ALU_OP        = r_ir[24:21];
        Rn_Addr       = r_ir[19:16];
        Rd_Addr       = r_ir[15:12];
        Rm_Addr       = '0;
        Rs_Addr       = '0;
        SHIFT_OP      = c_sh_lsl_imm;
        Shift_Imm     = '0;
        Shift_Num_Sel = 1'b0;
        Imm_Sel       = 1'b0;
        Imm_Out       = '0;
        if (r_ir[25]) begin
            Imm_Sel   = 1'b1;
            SHIFT_OP  = c_sh_ror_imm;
            Shift_Imm = {3'b000, r_ir[11:8], 1'b0};
            Imm_Out   = {24'h000000, r_ir[7:0]};
        end else begin
            Rm_Addr = r_ir[3:0];
            if (!r_ir[4]) begin
                SHIFT_OP  = {r_ir[6:5], 1'b0};
                Shift_Imm = {3'b000, r_ir[11:7]};
            end else begin
                SHIFT_OP      = {r_ir[6:5], 1'b1};
                Rs_Addr       = r_ir[11:8];
                Shift_Num_Sel = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dp_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_controller
// Desc     : Self-checking bench: directed vector table, reset abort, random ops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dp_controller;

    logic        clk = 1'b0;
    logic        Rst;
    logic        Inst_Valid;
    logic [31:0] Inst;
    logic        Inst_Ready;
    logic [3:0]  NZCV;
    logic [3:0]  Rn_Addr, Rm_Addr, Rs_Addr, Rd_Addr;
    logic [3:0]  ALU_OP;
    logic [2:0]  SHIFT_OP;
    logic [7:0]  Shift_Imm;
    logic        Shift_Num_Sel, Imm_Sel;
    logic [31:0] Imm_Out;
    logic        LF, S, Write_Reg, Done, Skipped, Illegal;

    int checks   = 0;
    int failures = 0;

    dp_controller dut (
        .clk           (clk),
        .Rst           (Rst),
        .Inst_Valid    (Inst_Valid),
        .Inst          (Inst),
        .Inst_Ready    (Inst_Ready),
        .NZCV          (NZCV),
        .Rn_Addr       (Rn_Addr),
        .Rm_Addr       (Rm_Addr),
        .Rs_Addr       (Rs_Addr),
        .Rd_Addr       (Rd_Addr),
        .ALU_OP        (ALU_OP),
        .SHIFT_OP      (SHIFT_OP),
        .Shift_Imm     (Shift_Imm),
        .Shift_Num_Sel (Shift_Num_Sel),
        .Imm_Sel       (Imm_Sel),
        .Imm_Out       (Imm_Out),
        .LF            (LF),
        .S             (S),
        .Write_Reg     (Write_Reg),
        .Done          (Done),
        .Skipped       (Skipped),
        .Illegal       (Illegal)
    );

    always #5 clk = ~clk;

    // kind: 0 = executes, 1 = condition fails, 2 = illegal
    typedef struct {
        logic [31:0] inst;
        logic [3:0]  nzcv;
        logic [1:0]  kind;
        logic        wr;
        logic        s;
        logic [64:0] dec;
    } vec_t;

    logic [64:0] w_act_dec;
    logic [6:0]  w_act_st;
    assign w_act_dec = {ALU_OP, SHIFT_OP, Shift_Imm, Shift_Num_Sel, Imm_Sel, Imm_Out,
                        Rn_Addr, Rm_Addr, Rs_Addr, Rd_Addr};
    assign w_act_st  = {Inst_Ready, LF, S, Write_Reg, Done, Skipped, Illegal};

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [64:0] mk_dec(input logic [3:0] alu, input logic [2:0] shop,
                                           input logic [7:0] shimm, input logic nsel,
                                           input logic isel, input logic [7:0] imm,
                                           input logic [3:0] rn, input logic [3:0] rm,
                                           input logic [3:0] rs, input logic [3:0] rd);
        return {alu, shop, shimm, nsel, isel, {24'h0, imm}, rn, rm, rs, rd};
    endfunction

    function automatic vec_t mk(input logic [31:0] inst, input logic [3:0] nzcv,
                                input logic [1:0] kind, input logic wr, input logic s,
                                input logic [64:0] dec);
        vec_t v;
        v.inst = inst; v.nzcv = nzcv; v.kind = kind; v.wr = wr; v.s = s; v.dec = dec;
        return v;
    endfunction

    // Reference: condition table written as "base test on cond[3:1], inverted by cond[0]"
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    function automatic vec_t model(input logic [31:0] ins, input logic [3:0] f);
        vec_t v;
        bit   ill;
        logic [2:0] shop;
        logic [7:0] shimm, imm;
        logic [3:0] rm, rs;
        logic nsel, isel;
        ill = (ins[27:26] != 0) || (!ins[25] && ins[4] && ins[7])
              || (ins[24:23] == 2'b10 && !ins[20]);
        shop = 0; shimm = 0; imm = 0; rm = 0; rs = 0; nsel = 0; isel = 0;
        if (ins[25]) begin
            shop = 3'd6; shimm = 8'(ins[11:8]) * 8'd2; imm = ins[7:0]; isel = 1;
        end else if (!ins[4]) begin
            rm = ins[3:0]; shop = 3'(ins[6:5]) * 3'd2; shimm = 8'(ins[11:7]);
        end else begin
            rm = ins[3:0]; rs = ins[11:8]; shop = 3'(ins[6:5]) * 3'd2 + 3'd1; nsel = 1;
        end
        v.inst = ins; v.nzcv = f; v.s = ins[20];
        v.kind = ill ? 2'd2 : (cond_ok(ins[31:28], f) ? 2'd0 : 2'd1);
        v.wr   = (v.kind == 0) && (ins[24:23] != 2'b10);
        v.dec  = mk_dec(ins[24:21], shop, shimm, nsel, isel, imm, ins[19:16], rm, rs,
                        ins[15:12]);
        return v;
    endfunction

    task automatic run_inst(input vec_t v, input string tag);
        int waited = 0;
        logic [6:0] st1;
        @(negedge clk);
        Inst = v.inst; NZCV = v.nzcv; Inst_Valid = 1'b1;
        while (!Inst_Ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, " ready"}, 80'(Inst_Ready), 80'd1);
        if (!Inst_Ready) begin
            Inst_Valid = 1'b0;
            return;
        end
        @(negedge clk);
        Inst_Valid = 1'b0;
        Inst = $urandom;
        st1 = (v.kind == 0) ? 7'b0000000 : (v.kind == 1) ? 7'b0000110 : 7'b0000101;
        chk({tag, " decode strobes"}, 80'(w_act_st), 80'(st1));
        if (v.kind != 2) chk({tag, " decode fields"}, 80'(w_act_dec), 80'(v.dec));
        if (v.kind == 0) begin
            @(negedge clk);
            NZCV = 4'($urandom);
            chk({tag, " exec strobes"}, 80'(w_act_st), 80'({3'b010 | {2'b00, v.s}, 4'b0000}));
            chk({tag, " exec fields"}, 80'(w_act_dec), 80'(v.dec));
            @(negedge clk);
            chk({tag, " wb strobes"}, 80'(w_act_st), 80'({3'b000, v.wr, 3'b100}));
            chk({tag, " wb fields"}, 80'(w_act_dec), 80'(v.dec));
        end
        @(negedge clk);
        chk({tag, " back to idle"}, 80'(w_act_st), 80'(7'b1000000));
    endtask

    vec_t tbl[13];

    initial begin
        tbl[0]  = mk(32'hE2921E3F, 4'h0, 0, 1, 1, mk_dec(4'h4, 3'd6, 8'd28, 0, 1, 8'h3F, 4'd2, 4'd0, 4'd0, 4'd1));
        tbl[1]  = mk(32'hE1530004, 4'h0, 0, 0, 1, mk_dec(4'hA, 3'd0, 8'd0, 0, 0, 8'h00, 4'd3, 4'd4, 4'd0, 4'd0));
        tbl[2]  = mk(32'h01A00001, 4'h0, 1, 0, 0, mk_dec(4'hD, 3'd0, 8'd0, 0, 0, 8'h00, 4'd0, 4'd1, 4'd0, 4'd0));
        tbl[3]  = mk(32'hE1A05716, 4'h0, 0, 1, 0, mk_dec(4'hD, 3'd1, 8'd0, 1, 0, 8'h00, 4'd0, 4'd6, 4'd7, 4'd5));
        tbl[4]  = mk(32'hE0000090, 4'h0, 2, 0, 0, '0);
        tbl[5]  = mk(32'h01A00001, 4'h4, 0, 1, 0, mk_dec(4'hD, 3'd0, 8'd0, 0, 0, 8'h00, 4'd0, 4'd1, 4'd0, 4'd0));
        tbl[6]  = mk(32'hF1A00001, 4'hF, 1, 0, 0, mk_dec(4'hD, 3'd0, 8'd0, 0, 0, 8'h00, 4'd0, 4'd1, 4'd0, 4'd0));
        tbl[7]  = mk(32'hE1430004, 4'h0, 2, 0, 0, '0);
        tbl[8]  = mk(32'hE4000000, 4'h0, 2, 0, 0, '0);
        tbl[9]  = mk(32'hE1A010A2, 4'h0, 0, 1, 0, mk_dec(4'hD, 3'd2, 8'd1, 0, 0, 8'h00, 4'd0, 4'd2, 4'd0, 4'd1));
        tbl[10] = mk(32'hC0812003, 4'h8, 1, 0, 0, mk_dec(4'h4, 3'd0, 8'd0, 0, 0, 8'h00, 4'd1, 4'd3, 4'd0, 4'd2));
        tbl[11] = mk(32'hC0812003, 4'h9, 0, 1, 0, mk_dec(4'h4, 3'd0, 8'd0, 0, 0, 8'h00, 4'd1, 4'd3, 4'd0, 4'd2));
        tbl[12] = mk(32'hE3100001, 4'h0, 0, 0, 1, mk_dec(4'h8, 3'd6, 8'd0, 0, 1, 8'h01, 4'd0, 4'd0, 4'd0, 4'd0));

        Rst = 1'b1; Inst_Valid = 1'b0; Inst = '0; NZCV = '0;
        repeat (2) @(negedge clk);
        chk("reset strobes", 80'(w_act_st), 80'(7'b1000000));
        chk("reset fields", 80'(w_act_dec), 80'd0);
        Rst = 1'b0;

        for (int i = 0; i < 13; i++) run_inst(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of EXEC must abort without write-back
        @(negedge clk);
        Inst = 32'hE2921E3F; NZCV = 4'h0; Inst_Valid = 1'b1;
        @(negedge clk);
        Inst_Valid = 1'b0;
        @(negedge clk);
        chk("pre-reset exec", 80'(w_act_st), 80'(7'b0110000));
        #2 Rst = 1'b1;
        #1;
        chk("mid-exec reset strobes", 80'(w_act_st), 80'(7'b1000000));
        chk("mid-exec reset fields", 80'(w_act_dec), 80'd0);
        @(negedge clk);
        Rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("post-reset idle %0d", k), 80'(w_act_st), 80'(7'b1000000));
            @(negedge clk);
        end
        run_inst(tbl[0], "after reset");

        for (int r = 0; r < 150; r++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(0, 7) != 0) ins[27:26] = 2'b00;
            if ($urandom_range(0, 2) == 0) ins[31:28] = 4'hE;
            if (!ins[25] && ins[4] && $urandom_range(0, 3) != 0) ins[7] = 1'b0;
            run_inst(model(ins, 4'($urandom)), $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/dp_controller.md
DP_CONTROLLER -- requirements
Module: dp_controller

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit, system clock; all state updates occur on the rising edge.
REQ-002 The block SHALL have the port Rst, input, 1 bit, reset; asynchronous, active-high.
REQ-003 The block SHALL have the ports Inst_Valid (input, 1), Inst (input, 32) and Inst_Ready (output, 1) as the instruction handshake.
REQ-004 The block SHALL have the input NZCV, 4 bits, current flags in the order {N,Z,C,V}.
REQ-005 The block SHALL have the outputs Rn_Addr, Rm_Addr, Rs_Addr and Rd_Addr, 4 bits each, register-file addresses.
REQ-006 The block SHALL have the outputs ALU_OP (4), SHIFT_OP (3), Shift_Imm (8), Shift_Num_Sel (1) and Imm_Sel (1); Shift_Num_Sel=1 selects Rs[7:0]; Imm_Sel=1 selects Imm_Out as Shift_Data.
REQ-007 The block SHALL have the output Imm_Out, 32 bits, the zero-extended imm8.
REQ-008 The block SHALL have the outputs LF, S and Write_Reg, 1 bit each, strobes to the ALU/shift stage and to the register file.
REQ-009 The block SHALL have the outputs Done, Skipped and Illegal, 1 bit each, one-cycle completion pulses.

Function
REQ-010 The FSM SHALL have the states IDLE, DECODE, EXEC and WB.
REQ-011 Inst_Ready SHALL be 1 only in IDLE; Inst_Valid&Inst_Ready SHALL latch Inst into IR and move the FSM to DECODE.
REQ-012 All decode outputs SHALL derive from the registered IR and SHALL be stable from DECODE through WB.
REQ-013 Fields: cond=IR[31:28], I=IR[25], opcode=IR[24:21], Sbit=IR[20], Rn=IR[19:16], Rd=IR[15:12]; ALU_OP SHALL equal opcode.
REQ-014 I=1: Imm_Sel=1, SHIFT_OP=ROR-imm (110), Shift_Imm={IR[11:8],1'b0}, Imm_Out=IR[7:0].
REQ-015 I=0, IR[4]=0: Rm_Addr=IR[3:0], SHIFT_OP={IR[6:5],1'b0}, Shift_Imm=IR[11:7], Shift_Num_Sel=0.
REQ-016 I=0, IR[4]=1, IR[7]=0: SHIFT_OP={IR[6:5],1'b1}, Rs_Addr=IR[11:8], Shift_Num_Sel=1.
REQ-017 DECODE SHALL flag Illegal if IR[27:26]!=00, if I=0&IR[4]&IR[7], or if opcode=10xx with Sbit=0; Illegal pulses, Done pulses and the FSM returns to IDLE.
REQ-018 DECODE SHALL evaluate cond against NZCV per the 15 ARM conditions; 1111 is false; on failure Skipped and Done pulse and the FSM returns to IDLE.
REQ-019 EXEC SHALL assert LF=1 and S=Sbit for exactly that cycle; the downstream stage latches on the falling edge within it.
REQ-020 WB SHALL assert Write_Reg=1 with Rd_Addr=Rd unless opcode=10xx (TST/TEQ/CMP/CMN), pulse Done, and return to IDLE.
REQ-021 Latency: a passing instruction accepted at edge 0 SHALL produce EXEC at cycle 2 and WB/Done at cycle 3, with the next accept possible at cycle 4.
REQ-022 MOV/MVN (1101/1111) SHALL still drive Rn_Addr; the ALU ignores it.
REQ-023 LF, S, Write_Reg, Done, Skipped and Illegal SHALL never be asserted simultaneously with Inst_Ready.

Reset
REQ-024 Rst SHALL force IDLE, IR=0, and every output to 0 except Inst_Ready=1, from any state.
REQ-025 Rst asserted mid-instruction SHALL abort it with no Write_Reg, Done or Skipped.

Structure
REQ-026 Package dp_pkg SHALL hold the state enum, SHIFT_OP encodings (LSL/LSR/ASR/ROR x imm/reg), the opcode constants and the cond constants.
REQ-027 The combinational sub-module cond_check(cond, NZCV -> pass) SHALL be instantiated once.

Verification
REQ-028 For Inst=0xE2921E3F with NZCV=0000: ALU_OP=0100, SHIFT_OP=110, Shift_Imm=28, Imm_Out=0x3F, Imm_Sel=1, LF=S=1 in EXEC, Write_Reg with Rd_Addr=1 in WB.
REQ-029 For Inst=0xE1530004: Rn=3, Rm=4, ALU_OP=1010, SHIFT_OP=000, S=1 in EXEC, no Write_Reg, Done at cycle 3.
REQ-030 For Inst=0x01A00001 with NZCV=0000: Skipped=Done=1 at DECODE, no LF/S/Write_Reg, Inst_Ready=1 the next cycle.
REQ-031 For Inst=0xE1A05716: SHIFT_OP=001, Shift_Num_Sel=1, Rs_Addr=7, Rm_Addr=6, Write_Reg with Rd_Addr=5.
REQ-032 For Inst=0xE0000090 (MUL): Illegal=Done=1, no LF/S/Write_Reg.
REQ-033 Rst pulsed during EXEC: all outputs 0, Inst_Ready=1, no Write_Reg, and the next instruction executes normally.
